// File: rtl/aes_kat_engine_if.sv
// Bus between the AES known-answer-test sequencer and its surroundings:
// core drive/return, run control and result reporting.
interface aes_kat_engine_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             loop;
  logic [127:0]     state;
  logic [127:0]     key;
  logic [127:0]     core_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic             fail_valid;
  logic [1:0]       first_fail;

  modport master (
    input  start, loop, core_out,
    output state, key, busy, done, pass, err_cnt, fail_valid, first_fail
  );

  modport slave (
    output start, loop, core_out,
    input  state, key, busy, done, pass, err_cnt, fail_valid, first_fail
  );
endinterface

// File: rtl/aes_kat_engine.sv
// Known-answer-test sequencer for a pipelined AES-128 core: issues ROM vectors
// one per cycle, checks each result LATENCY cycles later and reports pass/fail.
module aes_kat_engine #(
  parameter int LATENCY = 21,
  parameter int NUM_VEC = 4,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_kat_engine_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} fsm_e;

  localparam logic [1:0]       LAST_IDX = 2'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  localparam logic [127:0] ROM_PT [4] = '{
    128'h3243f6a8885a308d313198a2e0370734, 128'h00112233445566778899aabbccddeeff,
    128'h0,                                128'h6bc1bee22e409f96e93d7e117393172a};
  localparam logic [127:0] ROM_KEY [4] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h000102030405060708090a0b0c0d0e0f,
    128'h0,                                128'h2b7e151628aed2a6abf7158809cf4f3c};
  localparam logic [127:0] ROM_CT [4] = '{
    128'h3925841d02dc09fbdc118597196a0b32, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
    128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h3ad77bb40d7a3660a89ecaf32466ef97};

  fsm_e                        r_fsm, w_fsm_nxt;
  logic                        w_load, w_start_run, w_finish, w_upstream_vld, w_mismatch;
  logic [1:0]                  w_load_idx;
  logic                        r_issue_vld;
  logic [1:0]                  r_issue_tag;
  logic [LATENCY-1:0]          r_vld_pipe;
  logic [LATENCY-1:0][1:0]     r_tag_pipe;
  logic [127:0]                r_state, r_key;
  logic                        r_busy, r_done, r_pass, r_fail_valid;
  logic [1:0]                  r_first_fail;
  logic [ERR_W-1:0]            r_err_cnt;

  // Vectors still upstream of the compare stage; once none remain, the
  // compare on the next edge is the last one of the run.
  always_comb begin
    w_upstream_vld = r_issue_vld;
    for (int k = 0; k < LATENCY - 1; k++) w_upstream_vld = w_upstream_vld | r_vld_pipe[k];
  end

  assign w_mismatch = r_vld_pipe[LATENCY-1] &&
                      (bus.core_out != ROM_CT[r_tag_pipe[LATENCY-1]]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    w_fsm_nxt   = r_fsm;
    w_load      = 1'b0;
    w_load_idx  = '0;
    w_start_run = 1'b0;
    w_finish    = 1'b0;
    case (r_fsm)
      S_IDLE: if (bus.start) begin
        w_start_run = 1'b1;
        w_load      = 1'b1;
        w_fsm_nxt   = S_ISSUE;
      end
      S_ISSUE: begin
        if (r_issue_tag != LAST_IDX) begin
          w_load     = 1'b1;
          w_load_idx = r_issue_tag + 2'd1;
        end else if (bus.loop) begin
          w_load = 1'b1;
        end else begin
          w_fsm_nxt = S_DRAIN;
        end
      end
      S_DRAIN: if (!w_upstream_vld) w_fsm_nxt = S_FIN;
      S_FIN: begin
        w_finish  = 1'b1;
        w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the tag delay line is tiny control state, so it is reset like any flop; a stale
    // valid bit after reset would produce a phantom compare.
    if (!rst_n) begin
      r_issue_vld  <= 1'b0;
      r_issue_tag  <= '0;
      r_vld_pipe   <= '0;
      r_tag_pipe   <= '0;
      r_state      <= '0;
      r_key        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
      r_err_cnt    <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every stage reads its neighbour's pre-edge value.
      r_issue_vld   <= w_load;
      r_issue_tag   <= w_load_idx;
      r_state       <= w_load ? ROM_PT[w_load_idx]  : '0;
      r_key         <= w_load ? ROM_KEY[w_load_idx] : '0;
      r_vld_pipe[0] <= r_issue_vld;
      r_tag_pipe[0] <= r_issue_tag;
      for (int k = 1; k < LATENCY; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        r_tag_pipe[k] <= r_tag_pipe[k-1];
      end

      if (w_start_run) begin
        r_busy       <= 1'b1;
        r_done       <= 1'b0;
        r_pass       <= 1'b0;
        r_fail_valid <= 1'b0;
        r_first_fail <= '0;
        r_err_cnt    <= '0;
      end else if (w_mismatch) begin
        if (r_err_cnt != ERR_MAX) r_err_cnt <= r_err_cnt + 1'b1;
        if (!r_fail_valid) begin
          r_fail_valid <= 1'b1;
          r_first_fail <= r_tag_pipe[LATENCY-1];
        end
      end

      if (w_finish) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_pass <= (r_err_cnt == '0);
      end
    end
  end

  assign bus.state      = r_state;
  assign bus.key        = r_key;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.pass       = r_pass;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.fail_valid = r_fail_valid;
  assign bus.first_fail = r_first_fail;
endmodule

// File: doc/aes_kat_engine.md
Name: aes_kat_engine

Overview:
- Synthesizable known-answer-test sequencer for the pipelined aes_128 core. It drives up to four built-in FIPS-197 / SP800-38A vectors back-to-back, one per cycle.
- Each core result is checked against its expected ciphertext after a parametrised pipeline latency. The block counts mismatches and reports pass/fail.
- Optional loop mode repeats the vector set continuously for soak testing.
- Sits beside aes_128 on power-up self-test paths and in bring-up benches.

Parameters:
- LATENCY, 21, cycles from the edge that samples state/key into the core to the edge at which the matching core_out is checked (1..63).
- NUM_VEC, 4, number of ROM vectors issued per pass (1..4).
- ERR_W, 8, width of the saturating mismatch counter (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a run; sampled only in IDLE
- loop  input  1  repeat passes while high; sampled at the end of each pass
- state  output  128  plaintext to core, registered
- key  output  128  key to core, registered
- core_out  input  128  ciphertext from core
- busy  output  1  run in progress
- done  output  1  sticky; run complete, cleared by next accepted start
- pass  output  1  done && err_cnt==0
- err_cnt  output  ERR_W  mismatch count, saturates at all-ones
- fail_valid  output  1  at least one mismatch this run
- first_fail  output  2  ROM index of first mismatch this run

Behaviour:
- One clock (clk); reset rst_n asynchronous, active-low. Asserting rst_n low forces immediately:
  - state=0, key=0, busy=0, done=0, pass=0, err_cnt=0, fail_valid=0, first_fail=0.
  - FSM to IDLE, tag delay line cleared.
  - Reset mid-run abandons the run; no done pulse follows.
- ROM, index: plaintext / key / expected ciphertext
  - 0: 3243f6a8885a308d313198a2e0370734 / 2b7e151628aed2a6abf7158809cf4f3c / 3925841d02dc09fbdc118597196a0b32
  - 1: 00112233445566778899aabbccddeeff / 000102030405060708090a0b0c0d0e0f / 69c4e0d86a7b0430d8cdb78070b4c55a
  - 2: all-zero / all-zero / 66e94bd4ef8a2c3b884cfa59ca342b2e
  - 3: 6bc1bee22e409f96e93d7e117393172a / 2b7e151628aed2a6abf7158809cf4f3c / 3ad77bb40d7a3660a89ecaf32466ef97
- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE, start=1 at edge E0:
    - clear err_cnt, fail_valid, first_fail, done, pass; busy<=1.
    - load vector 0 into state/key; go ISSUE.
  - ISSUE:
    - vector i is driven in the cycle after edge E0+i; the core samples it at edge E0+i+1.
    - a valid bit plus 2-bit tag enters a delay line.
    - after vector NUM_VEC-1 is loaded:
      - loop=1: next edge loads vector 0 (wrap, no bubble).
      - else: go DRAIN; state/key return to 0.
  - DRAIN: wait until the delay line is empty, then go FIN.
  - FIN: done<=1, pass<=(err_cnt==0), busy<=0, go IDLE.
- Check timing: vector i is compared at edge E0+i+1+LATENCY, 128-bit exact equality (core_out vs ROM expected).
  - On mismatch: err_cnt+1, saturating at all-ones.
  - If fail_valid was 0: set fail_valid and first_fail<=tag.
  - Compares are only performed where the tag is valid; core_out is don't-care elsewhere.
- Single pass: busy falls and done/pass rise at edge E0+NUM_VEC+LATENCY+1.
- Loop mode: multiple in-flight passes are tracked by tag only. err_cnt accumulates across passes. first_fail holds the first failure of the whole run.
- start while busy=1: ignored, no effect.
- loop change mid-pass: takes effect only at the pass boundary.
- done/pass remain high in IDLE until the next accepted start clears them at that edge.

Test Plan:
- Ideal core model (LATENCY=21, NUM_VEC=4), start at edge 0 -> four vectors on state/key in cycles 1..4. At edge 26: busy=0, done=1, pass=1, err_cnt=0, fail_valid=0.
- Model corrupts bit 0 of vector 2 result -> at edge 26: err_cnt=1, fail_valid=1, first_fail=2, pass=0.
- loop=1 held for 3 passes, then dropped, every result wrong, ERR_W=2 -> err_cnt saturates at 3, first_fail=0, done after final drain.
- rst_n pulsed low at cycle 10 of a run -> all outputs 0 immediately. No done afterwards. A new start then passes normally.
- start pulsed at cycles 3 and 5 during a run -> ignored; single completion at edge 26 with pass=1.
- LATENCY=1, NUM_VEC=1 -> vector 0 driven cycle 1, compared at edge 2, done=1 at edge 3.
